// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: RV32I multicycle fetch stage -- PC, one outstanding imem read, IR valid/ready to decode.
// Optional IFETCH_ALIGN_CHECK_EN: misaligned redirect targets trap in a FAULT state instead of being truncated.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] mem_addr,
   output logic        mem_rd,
   input  logic        mem_waitrequest,
   input  logic [31:0] mem_rddata,
   output logic [31:0] ir,
   output logic [31:0] ir_pc,
   output logic        ir_valid,
   input  logic        ir_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        fetch_fault
);

`ifdef IFETCH_ALIGN_CHECK_EN
   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_HOLD, S_FAULT} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_HOLD} state_t;
`endif

   state_t      r_state, w_state_nxt;
   logic [31:0] r_pc, w_pc_nxt;
   logic [31:0] r_req_pc, w_req_pc_nxt;
   logic [31:0] r_ir, w_ir_nxt;
   logic [31:0] r_ir_pc, w_ir_pc_nxt;
   logic        r_ir_valid, w_ir_valid_nxt;

`ifdef IFETCH_ALIGN_CHECK_EN
   logic        r_fault, w_fault_nxt;
   logic        w_misaligned;
   assign w_misaligned = |redirect_pc[1:0];
   assign fetch_fault  = r_fault;
`else
   assign fetch_fault  = 1'b0;
`endif

   assign mem_addr = r_pc;
   assign ir       = r_ir;
   assign ir_pc    = r_ir_pc;
   assign ir_valid = r_ir_valid;

   always_comb begin
      w_state_nxt    = r_state;
      w_pc_nxt       = r_pc;
      w_req_pc_nxt   = r_req_pc;
      w_ir_nxt       = r_ir;
      w_ir_pc_nxt    = r_ir_pc;
      w_ir_valid_nxt = r_ir_valid;
      mem_rd         = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
      w_fault_nxt    = r_fault;
`endif
      case (r_state)
         S_IDLE:  w_state_nxt = S_FETCH;
         S_FETCH: begin
            mem_rd = 1'b1;
            if (!mem_waitrequest) begin
               w_req_pc_nxt = r_pc;
               w_state_nxt  = S_WAIT;
            end
         end
         S_WAIT: begin
            w_ir_nxt       = mem_rddata;
            w_ir_pc_nxt    = r_req_pc;
            w_ir_valid_nxt = 1'b1;
            w_pc_nxt       = r_req_pc + 32'd4;
            w_state_nxt    = S_HOLD;
         end
         S_HOLD: begin
            if (ir_ready) begin
               w_ir_valid_nxt = 1'b0;
               w_state_nxt    = S_FETCH;
            end
         end
`ifdef IFETCH_ALIGN_CHECK_EN
         S_FAULT: w_state_nxt = S_FAULT;
`endif
         default: w_state_nxt = S_IDLE;
      endcase

      // Redirect overrides everything above, including a WAIT-cycle capture of stale data.
      if (redirect) begin
         w_ir_valid_nxt = 1'b0;
         w_ir_nxt       = NOP_INSTR;
         w_state_nxt    = S_FETCH;
         w_pc_nxt       = redirect_pc & ~32'h3;
`ifdef IFETCH_ALIGN_CHECK_EN
         w_fault_nxt    = 1'b0;
         if (w_misaligned) begin
            w_pc_nxt    = redirect_pc;
            w_state_nxt = S_FAULT;
            w_fault_nxt = 1'b1;
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_pc       <= RESET_PC;
         r_req_pc   <= RESET_PC;
         r_ir       <= NOP_INSTR;
         r_ir_pc    <= '0;
         r_ir_valid <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_pc       <= w_pc_nxt;
         r_req_pc   <= w_req_pc_nxt;
         r_ir       <= w_ir_nxt;
         r_ir_pc    <= w_ir_pc_nxt;
         r_ir_valid <= w_ir_valid_nxt;
      end
   end

`ifdef IFETCH_ALIGN_CHECK_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_fault <= 1'b0;
      else        r_fault <= w_fault_nxt;
   end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: scoreboard bench for the fetch stage; program-order fetch model plus directed timing checks.
module tb_instr_fetch_unit;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] mem_addr;
   logic        mem_rd;
   logic        mem_waitrequest = 1'b0;
   logic [31:0] mem_rddata = '0;
   logic [31:0] ir;
   logic [31:0] ir_pc;
   logic        ir_valid;
   logic        ir_ready = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        fetch_fault;

   always #5 clk = ~clk;

   instr_fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
      .clk(clk), .reset(reset),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_waitrequest(mem_waitrequest), .mem_rddata(mem_rddata),
      .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
      .redirect(redirect), .redirect_pc(redirect_pc), .fetch_fault(fetch_fault)
   );

   typedef struct packed {
      logic [31:0] word;
      logic [31:0] pc;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int unsigned vectors = 0;
   int unsigned miscompares = 0;
   int unsigned handshakes = 0;
   logic [31:0] model_pc = '0;
   bit          pending = 1'b0;
   bit          model_fault = 1'b0;
   bit          flushed = 1'b0;
   bit          busy = 1'b0;
   bit          mem_acc = 1'b0;
   logic [31:0] mem_acc_addr = '0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'h0050_0093;
      return {a[15:0], a[31:16]} ^ 32'hA5C3_0F13;
   endfunction

   task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
      end
   endtask

   task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] req);
      chk(act === req, name, act, req);
   endtask

   // Monitor + reference model: fetch stream in program order, restarted by each redirect.
   always @(negedge clk) begin
      if (!reset) begin
         model_pc    = 32'h0;
         pending     = 1'b0;
         model_fault = 1'b0;
         flushed     = 1'b0;
         mem_acc     = 1'b0;
         exp_q.delete();
      end else begin
         busy = pending || (exp_q.size() != 0);
         chk_eq("ir_valid", 32'(ir_valid), 32'(exp_q.size() != 0));
         if (ir_valid && ir_ready && exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk_eq("ir", ir, mon_e.word);
            chk_eq("ir_pc", ir_pc, mon_e.pc);
            handshakes++;
         end
         if (flushed) chk_eq("ir_flushed", ir, NOP);
         if (busy) chk_eq("single_outstanding", 32'(mem_rd), 32'h0);
`ifdef IFETCH_ALIGN_CHECK_EN
         chk_eq("fetch_fault", 32'(fetch_fault), 32'(model_fault));
         if (model_fault) chk_eq("no_read_in_fault", 32'(mem_rd), 32'h0);
`else
         chk_eq("fetch_fault", 32'(fetch_fault), 32'h0);
`endif
         if (mem_rd) chk_eq("mem_addr", mem_addr, model_pc);
         mem_acc      = mem_rd && !mem_waitrequest;
         mem_acc_addr = mem_addr;
         if (redirect) begin
            exp_q.delete();
            pending = 1'b0;
            flushed = 1'b1;
`ifdef IFETCH_ALIGN_CHECK_EN
            model_fault = (redirect_pc[1:0] != 2'b00);
            model_pc    = model_fault ? redirect_pc : (redirect_pc & ~32'h3);
`else
            model_pc    = redirect_pc & ~32'h3;
`endif
         end else begin
            flushed = 1'b0;
            if (pending) begin
               exp_q.push_back('{word: mem_word(model_pc), pc: model_pc});
               model_pc = model_pc + 32'd4;
               pending  = 1'b0;
            end else if (mem_acc) begin
               pending = 1'b1;
            end
         end
      end
   end

   // One clock cycle of stimulus; memory answers the previous cycle's accepted read.
   task automatic cyc(input bit w, input bit r, input bit rd, input logic [31:0] rpc);
      @(posedge clk);
      #1;
      mem_waitrequest = w;
      ir_ready        = r;
      redirect        = rd;
      redirect_pc     = rpc;
      mem_rddata      = !mem_acc ? 32'h0BAD_F00D : (rd ? 32'hDEAD_BEEF : mem_word(mem_acc_addr));
      @(negedge clk);
   endtask

   task automatic chk_reset_state(input string tag);
      chk_eq({tag, "_mem_rd"}, 32'(mem_rd), 32'h0);
      chk_eq({tag, "_mem_addr"}, mem_addr, 32'h0);
      chk_eq({tag, "_ir"}, ir, NOP);
      chk_eq({tag, "_ir_pc"}, ir_pc, 32'h0);
      chk_eq({tag, "_ir_valid"}, 32'(ir_valid), 32'h0);
      chk_eq({tag, "_fault"}, 32'(fetch_fault), 32'h0);
   endtask

   initial begin
      bit w, r, rd;
      logic [31:0] rpc;
      repeat (3) @(negedge clk);
      chk_reset_state("reset");

      @(posedge clk);
      #1;
      reset = 1'b1;
      ir_ready = 1'b1;
      @(negedge clk);
      chk_eq("idle_dead_cycle", 32'(mem_rd), 32'h0);
      cyc(0, 1, 0, 0);
      chk_eq("first_rd", 32'(mem_rd), 32'h1);
      chk_eq("first_addr", mem_addr, 32'h0);
      cyc(0, 1, 0, 0);
      chk_eq("wait_no_valid", 32'(ir_valid), 32'h0);
      cyc(0, 1, 0, 0);
      chk_eq("c4_valid", 32'(ir_valid), 32'h1);
      chk_eq("c4_ir", ir, 32'h0050_0093);
      chk_eq("c4_ir_pc", ir_pc, 32'h0);
      cyc(0, 1, 0, 0);
      chk_eq("second_addr", mem_addr, 32'h4);
      cyc(0, 1, 0, 0);
      cyc(0, 1, 0, 0);
      chk_eq("c7_valid", 32'(ir_valid), 32'h1);
      chk_eq("c7_ir_pc", ir_pc, 32'h4);

      for (int i = 0; i < 3; i++) begin
         cyc(1, 1, 0, 0);
         chk_eq("waitreq_rd", 32'(mem_rd), 32'h1);
         chk_eq("waitreq_addr", mem_addr, 32'h8);
      end
      cyc(0, 1, 0, 0);
      cyc(0, 1, 0, 0);
      chk_eq("post_wait_c1", 32'(ir_valid), 32'h0);
      cyc(0, 0, 0, 0);
      chk_eq("post_wait_c2", 32'(ir_valid), 32'h1);
      for (int i = 0; i < 4; i++) begin
         cyc(0, 0, 0, 0);
         chk_eq("hold_valid", 32'(ir_valid), 32'h1);
         chk_eq("hold_ir", ir, mem_word(32'h8));
         chk_eq("hold_ir_pc", ir_pc, 32'h8);
         chk_eq("hold_no_rd", 32'(mem_rd), 32'h0);
      end
      cyc(0, 1, 0, 0);
      cyc(0, 1, 0, 0);
      chk_eq("resume_rd", 32'(mem_rd), 32'h1);
      chk_eq("resume_addr", mem_addr, 32'hC);

      cyc(0, 1, 1, 32'h100);
      chk_eq("redir_in_wait_rd", 32'(mem_rd), 32'h0);
      cyc(0, 1, 0, 0);
      chk_eq("redir_addr", mem_addr, 32'h100);
      chk_eq("redir_valid", 32'(ir_valid), 32'h0);
      cyc(0, 1, 0, 0);
      cyc(0, 1, 0, 0);
      chk_eq("redir_ir", ir, mem_word(32'h100));
      chk_eq("redir_ir_pc", ir_pc, 32'h100);

      cyc(0, 1, 1, 32'hFFFF_FFFC);
      chk_eq("abandon_addr", mem_addr, 32'h104);
      cyc(0, 1, 0, 0);
      chk_eq("top_addr", mem_addr, 32'hFFFF_FFFC);
      cyc(0, 1, 0, 0);
      cyc(0, 1, 0, 0);
      chk_eq("top_ir_pc", ir_pc, 32'hFFFF_FFFC);
      cyc(0, 1, 0, 0);
      chk_eq("wrap_rd", 32'(mem_rd), 32'h1);
      chk_eq("wrap_addr", mem_addr, 32'h0);

      cyc(1, 1, 1, 32'h102);
      cyc(0, 1, 0, 0);
`ifdef IFETCH_ALIGN_CHECK_EN
      chk_eq("fault_set", 32'(fetch_fault), 32'h1);
      chk_eq("fault_no_rd", 32'(mem_rd), 32'h0);
`else
      chk_eq("trunc_fault", 32'(fetch_fault), 32'h0);
      chk_eq("trunc_addr", mem_addr, 32'h100);
`endif
      cyc(0, 1, 1, 32'h200);
      cyc(0, 1, 0, 0);
      chk_eq("realign_fault", 32'(fetch_fault), 32'h0);
      chk_eq("realign_rd", 32'(mem_rd), 32'h1);
      chk_eq("realign_addr", mem_addr, 32'h200);

      for (int i = 0; i < 3000; i++) begin
         w  = ($urandom_range(3) == 0);
         r  = ($urandom_range(2) != 0);
         rd = ($urandom_range(19) == 0);
         case ($urandom_range(3))
            0:       rpc = 32'hFFFF_FFFC;
            1:       rpc = $urandom() & 32'hFFFF_FFFC;
            2:       rpc = $urandom();
            default: rpc = 32'h100 + 32'($urandom_range(3));
         endcase
         cyc(w, r, rd, rpc);
      end
      chk(handshakes >= 100, "liveness", handshakes, 32'd100);

      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      chk_reset_state("async_reset");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage of the multicycle RV32I CPU; sits directly upstream of the IR decoder.
- Holds the PC and issues one instruction-memory read at a time.
- Captures the returned word into the IR and presents it to the decoder with a valid/ready handshake.
- Accepts PC redirects from the execute stage (branch, JAL, JALR) and discards any stale fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, IR value on reset and after a flush (addi x0,x0,0).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- mem_addr  output  32  instruction-memory byte address.
- mem_rd  output  1  read request.
- mem_waitrequest  input  1  memory not accepting; request is held while high.
- mem_rddata  input  32  read data, valid exactly 1 cycle after acceptance (mem_rd & !mem_waitrequest).
- ir  output  32  instruction word to the decoder.
- ir_pc  output  32  address ir was fetched from.
- ir_valid  output  1  ir/ir_pc hold an unconsumed instruction.
- ir_ready  input  1  decoder consumes ir this cycle when ir_valid=1.
- redirect  input  1  load redirect_pc, flush the pipeline.
- redirect_pc  input  32  redirect target.
- fetch_fault  output  1  misaligned redirect target (feature only; tied 0 otherwise).

Behaviour:
- Reset (reset=0, asynchronous): pc=RESET_PC, state=IDLE, mem_rd=0, mem_addr=RESET_PC, ir=NOP_INSTR, ir_pc=0, ir_valid=0, fetch_fault=0.
- States: IDLE, FETCH, WAIT, HOLD (plus FAULT with the feature).
- IDLE: no request; next cycle goes to FETCH. Exactly one dead cycle after reset release.
- FETCH: mem_rd=1, mem_addr=pc.
  - If mem_waitrequest=1: stay in FETCH, address held.
  - On acceptance: latch req_pc=pc, go to WAIT.
- WAIT: mem_rd=0. Sample mem_rddata this cycle: ir<=mem_rddata, ir_pc<=req_pc, ir_valid<=1, pc<=req_pc+4. Go to HOLD.
- HOLD: ir_valid=1, ir stable.
  - If ir_ready=1: ir_valid<=0, go to FETCH.
  - Otherwise hold indefinitely.
- Minimum throughput: 3 cycles per instruction (FETCH, WAIT, HOLD), zero-wait memory, ir_ready tied 1.
- PC arithmetic: 32-bit modulo. pc=32'hFFFF_FFFC increments to 32'h0000_0000 with no flag.
- Redirect has the highest priority and is evaluated in every state:
  - pc<=redirect_pc; ir_valid<=0; ir<=NOP_INSTR; next state FETCH.
  - In WAIT: the arriving mem_rddata is discarded; pc and ir are not updated from it.
  - In FETCH with mem_waitrequest=1: the pending request is abandoned and mem_addr changes to the new pc next cycle. The memory interface permits this.
  - In HOLD with ir_ready=1 in the same cycle: the handshake completes (decoder takes ir) and redirect still wins for pc.
- redirect_pc[1:0]: forced to 2'b00 when loaded into pc (feature off).
- ir_valid never asserts for a word whose request was accepted before the most recent redirect.
- Exactly one outstanding memory request at any time.

Optional Feature:
- Macro: IFETCH_ALIGN_CHECK_EN.
- Defined:
  - redirect with redirect_pc[1:0]!=0 enters FAULT: fetch_fault=1, mem_rd=0, ir_valid=0, pc<=redirect_pc unmodified.
  - FAULT is left only by reset or an aligned redirect, which goes to FETCH with fetch_fault<=0.
- Undefined:
  - low address bits are forced to zero, no FAULT state exists, and fetch_fault is constant 0.

Test Plan:
- Release reset, zero-wait memory returning 32'h00500093 at 0x0, ir_ready=1 -> mem_rd rises on cycle 2 with addr 0x0; ir=32'h00500093, ir_pc=0x0, ir_valid=1 on cycle 4; next fetch addr 0x4.
- mem_waitrequest held high 3 cycles in FETCH -> mem_addr and mem_rd stable for all 3; ir_valid rises 2 cycles after waitrequest drops.
- ir_ready=0 for 5 cycles in HOLD -> ir, ir_pc, ir_valid constant and no memory read issued; fetch resumes the cycle after ir_ready=1.
- redirect=1, redirect_pc=0x100 during WAIT, with mem_rddata=32'hDEADBEEF -> 0xDEADBEEF never appears on ir with ir_valid=1; next mem_addr=0x100.
- Start at pc=0xFFFF_FFFC -> after consumption the next mem_addr=0x0000_0000.
- Feature on: redirect_pc=0x102 -> fetch_fault=1 and no mem_rd; then redirect_pc=0x200 -> fetch_fault=0 and mem_addr=0x200.
